// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with hex decode, per-digit dp/blank,
// leading-zero suppression and frame-aligned double-buffered value updates.
module seg7_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit DIG_ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lz_blank,
   output logic [6:0]              seg,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    frame_start,
   output logic                    pending
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int VW = 4 * NUM_DIGITS;
   localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

   logic [PW-1:0]         pcnt_q, pcnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [VW-1:0]         sh_val_q, sh_val_d, act_val_q, act_val_d;
   logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
   logic                  pending_q, pending_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] dig_q, dig_d;
   logic                  fs_q, fs_d;

   logic                  tick, commit, upper_nz, suppress, cur_dp, cur_blank;
   logic [3:0]            cur_nib;
   logic [6:0]            seg_raw;
   logic [NUM_DIGITS-1:0] dig_raw;
   logic [VW-1:0]         src_val;
   logic [NUM_DIGITS-1:0] src_dp, src_blank;

   always_comb begin
      tick   = enable && (pcnt_q == PW'(REFRESH_DIV - 1));
      commit = tick && (idx_q == '0) && pending_q;

      // The committing frame's digit 0 decodes straight from the shadow.
      src_val   = commit ? sh_val_q   : act_val_q;
      src_dp    = commit ? sh_dp_q    : act_dp_q;
      src_blank = commit ? sh_blank_q : act_blank_q;

      cur_nib   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      upper_nz  = 1'b0;
      dig_raw   = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (IW'(k) == idx_q) begin
            cur_nib    = src_val[4*k +: 4];
            cur_dp     = src_dp[k];
            cur_blank  = src_blank[k];
            dig_raw[k] = 1'b1;
         end
         if ((IW'(k) >= idx_q) && (src_val[4*k +: 4] != 4'h0)) upper_nz = 1'b1;
      end
      suppress = lz_blank && (idx_q != '0) && !upper_nz;

      unique case (cur_nib)
         4'h0: seg_raw = 7'b1111110;
         4'h1: seg_raw = 7'b0110000;
         4'h2: seg_raw = 7'b1101101;
         4'h3: seg_raw = 7'b1111001;
         4'h4: seg_raw = 7'b0110011;
         4'h5: seg_raw = 7'b1011011;
         4'h6: seg_raw = 7'b1011111;
         4'h7: seg_raw = 7'b1110000;
         4'h8: seg_raw = 7'b1111111;
         4'h9: seg_raw = 7'b1111011;
         4'hA: seg_raw = 7'b1110111;
         4'hB: seg_raw = 7'b0011111;
         4'hC: seg_raw = 7'b1001110;
         4'hD: seg_raw = 7'b0111101;
         4'hE: seg_raw = 7'b1001111;
         default: seg_raw = 7'b1000111;
      endcase
      if (cur_blank || suppress) seg_raw = 7'b0000000;
   end

   always_comb begin
      pcnt_d      = pcnt_q;
      idx_d       = idx_q;
      sh_val_d    = sh_val_q;
      sh_dp_d     = sh_dp_q;
      sh_blank_d  = sh_blank_q;
      act_val_d   = act_val_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
      pending_d   = pending_q;
      seg_d       = seg_q;
      dp_d        = dp_q;
      dig_d       = dig_q;
      fs_d        = 1'b0;

      if (tick) begin
         pcnt_d = '0;
         idx_d  = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else if (enable) begin
         pcnt_d = pcnt_q + 1'b1;
      end

      if (commit) begin
         act_val_d   = sh_val_q;
         act_dp_d    = sh_dp_q;
         act_blank_d = sh_blank_q;
         pending_d   = 1'b0;
      end
      // A load on the committing tick lands in the shadow and re-arms pending.
      if (load) begin
         sh_val_d   = value_in;
         sh_dp_d    = dp_in;
         sh_blank_d = blank_in;
         pending_d  = 1'b1;
      end

      if (!enable) begin
         seg_d = SEG_OFF;
         dp_d  = DP_OFF;
         dig_d = DIG_OFF;
      end else if (tick) begin
         seg_d = seg_raw ^ SEG_OFF;
         dp_d  = (cur_dp && !cur_blank) ^ DP_OFF;
         dig_d = dig_raw ^ DIG_OFF;
         fs_d  = (idx_q == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt_q      <= '0;
         idx_q       <= '0;
         sh_val_q    <= '0;
         sh_dp_q     <= '0;
         sh_blank_q  <= '0;
         act_val_q   <= '0;
         act_dp_q    <= '0;
         act_blank_q <= '0;
         pending_q   <= 1'b0;
         seg_q       <= SEG_OFF;
         dp_q        <= DP_OFF;
         dig_q       <= DIG_OFF;
         fs_q        <= 1'b0;
      end else begin
         pcnt_q      <= pcnt_d;
         idx_q       <= idx_d;
         sh_val_q    <= sh_val_d;
         sh_dp_q     <= sh_dp_d;
         sh_blank_q  <= sh_blank_d;
         act_val_q   <= act_val_d;
         act_dp_q    <= act_dp_d;
         act_blank_q <= act_blank_d;
         pending_q   <= pending_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         dig_q       <= dig_d;
         fs_q        <= fs_d;
      end
   end

   assign seg         = seg_q;
   assign dp_out      = dp_q;
   assign dig_sel     = dig_q;
   assign frame_start = fs_q;
   assign pending     = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 4-cycle refresh): expected
// per-digit outputs are queued when values are loaded and popped as digits scan.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst, enable, load, lz_blank;
   logic [15:0] value_in;
   logic [3:0]  dp_in, blank_in, dig_sel;
   logic [6:0]  seg;
   logic        dp_out, frame_start, pending;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [3:0] dig;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .load(load), .value_in(value_in),
      .dp_in(dp_in), .blank_in(blank_in), .lz_blank(lz_blank), .seg(seg),
      .dp_out(dp_out), .dig_sel(dig_sel), .frame_start(frame_start), .pending(pending)
   );

   function automatic logic [6:0] dec(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
         4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
         4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
         4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
         4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
         4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
         4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
         4'hE: return 7'b1001111;  default: return 7'b1000111;
      endcase
   endfunction

   function automatic exp_t model(input logic [15:0] v, input logic [3:0] dp,
                                  input logic [3:0] bl, input logic lz, input int d);
      exp_t e;
      logic sup;
      sup   = lz && (d != 0) && ((v >> (4*d)) == 16'h0);
      e.seg = (bl[d] || sup) ? 7'h00 : dec(v[4*d +: 4]);
      e.dp  = dp[d] && !bl[d];
      e.dig = 4'(1 << d);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [15:0] v, input logic [3:0] dp,
                             input logic [3:0] bl, input logic lz);
      for (int d = 0; d < 4; d++) sb.push_back(model(v, dp, bl, lz, d));
   endtask

   task automatic load_val(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
      @(negedge clk);
      value_in = v; dp_in = dp; blank_in = bl; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_frame(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_start && n < 100);
      chk("frame_timeout", 32'(frame_start), 32'd1);
   endtask

   // Entered on the negedge showing frame_start; consumes the 16 cycles of one frame.
   task automatic check_frame(input string tag);
      exp_t e;
      e = '0;
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 4; c++) begin
            if (!(d == 0 && c == 0)) @(negedge clk);
            if (c == 0) begin
               if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
               else begin
                  e = sb.pop_front();
                  chk({tag, "_seg"}, 32'(seg), 32'(e.seg));
                  chk({tag, "_dp"}, 32'(dp_out), 32'(e.dp));
               end
            end
            chk({tag, "_dig"}, 32'(dig_sel), 32'(e.dig));
            chk({tag, "_fs"}, 32'(frame_start), 32'(d == 0 && c == 0));
         end
      end
   endtask

   initial begin
      int n;
      exp_t e;
      rst = 1'b1; enable = 1'b1; load = 1'b0; lz_blank = 1'b0;
      value_in = '0; dp_in = '0; blank_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_seg", 32'(seg), 32'd0);
      chk("rst_dp", 32'(dp_out), 32'd0);
      chk("rst_dig", 32'(dig_sel), 32'd0);
      chk("rst_fs", 32'(frame_start), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);

      // Reset release with an immediate load; first tick is REFRESH_DIV cycles later.
      rst = 1'b0; value_in = 16'h1234; load = 1'b1;
      push_frame(16'h1234, 4'h0, 4'h0, 1'b0);
      @(negedge clk);
      load = 1'b0;
      chk("first_pending", 32'(pending), 32'd1);
      wait_frame(n);
      chk("first_latency", 32'(n), 32'd3);
      check_frame("first");
      push_frame(16'h1234, 4'h0, 4'h0, 1'b0);
      wait_frame(n);
      chk("frame_period", 32'(n), 32'd1);
      check_frame("second");

      for (int v = 0; v < 16; v++) begin
         load_val(16'(v), 4'h0, 4'h0);
         push_frame(16'(v), 4'h0, 4'h0, 1'b0);
         wait_frame(n);
         check_frame("hex");
      end

      // Mid-frame load stays pending while the old frame finishes.
      load_val(16'h5678, 4'h0, 4'h0);
      push_frame(16'h5678, 4'h0, 4'h0, 1'b0);
      wait_frame(n);
      check_frame("base5678");
      repeat (4) @(negedge clk);
      load_val(16'hAAAA, 4'h0, 4'h0);
      chk("mid_pending", 32'(pending), 32'd1);
      e = model(16'h5678, 4'h0, 4'h0, 1'b0, 1);
      chk("mid_d1_seg", 32'(seg), 32'(e.seg));
      chk("mid_d1_dig", 32'(dig_sel), 32'(e.dig));
      repeat (7) @(negedge clk);
      e = model(16'h5678, 4'h0, 4'h0, 1'b0, 3);
      chk("mid_d3_seg", 32'(seg), 32'(e.seg));
      chk("mid_d3_pending", 32'(pending), 32'd1);
      wait_frame(n);
      chk("commit_pending", 32'(pending), 32'd0);
      push_frame(16'hAAAA, 4'h0, 4'h0, 1'b0);
      check_frame("commitAAAA");

      // Load asserted on the boundary tick: old shadow commits, new one waits a frame.
      repeat (4) @(negedge clk);
      load_val(16'h1111, 4'h0, 4'h0);
      repeat (10) @(negedge clk);
      value_in = 16'h2222; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("bnd_pending", 32'(pending), 32'd1);
      push_frame(16'h1111, 4'h0, 4'h0, 1'b0);
      check_frame("bnd1111");
      push_frame(16'h2222, 4'h0, 4'h0, 1'b0);
      wait_frame(n);
      chk("bnd_next_frame", 32'(n), 32'd1);
      check_frame("bnd2222");
      chk("bnd_pending_clr", 32'(pending), 32'd0);

      lz_blank = 1'b1;
      load_val(16'h0050, 4'b0100, 4'h0);
      push_frame(16'h0050, 4'b0100, 4'h0, 1'b1);
      wait_frame(n);
      check_frame("lz");
      load_val(16'h0050, 4'b0101, 4'b0001);
      push_frame(16'h0050, 4'b0101, 4'b0001, 1'b1);
      wait_frame(n);
      check_frame("blank");

      // Freeze scanning while idx points at digit 2; a load still gets captured.
      repeat (6) @(negedge clk);
      e = model(16'h0050, 4'b0101, 4'b0001, 1'b1, 1);
      chk("pre_en_seg", 32'(seg), 32'(e.seg));
      enable = 1'b0;
      @(negedge clk);
      chk("dis_seg", 32'(seg), 32'd0);
      chk("dis_dp", 32'(dp_out), 32'd0);
      chk("dis_dig", 32'(dig_sel), 32'd0);
      chk("dis_fs", 32'(frame_start), 32'd0);
      load_val(16'h9999, 4'h0, 4'h0);
      repeat (6) @(negedge clk);
      chk("dis_hold_dig", 32'(dig_sel), 32'd0);
      chk("dis_pending", 32'(pending), 32'd1);
      @(negedge clk);
      enable = 1'b1;
      repeat (2) @(negedge clk);
      chk("resume_early", 32'(dig_sel), 32'd0);
      @(negedge clk);
      e = model(16'h0050, 4'b0101, 4'b0001, 1'b1, 2);
      chk("resume_d2_dig", 32'(dig_sel), 32'(e.dig));
      chk("resume_d2_seg", 32'(seg), 32'(e.seg));
      chk("resume_d2_dp", 32'(dp_out), 32'(e.dp));
      repeat (4) @(negedge clk);
      e = model(16'h0050, 4'b0101, 4'b0001, 1'b1, 3);
      chk("resume_d3_dig", 32'(dig_sel), 32'(e.dig));
      chk("resume_d3_seg", 32'(seg), 32'(e.seg));
      chk("pre_rst_pending", 32'(pending), 32'd1);

      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_seg", 32'(seg), 32'd0);
      chk("arst_dp", 32'(dp_out), 32'd0);
      chk("arst_dig", 32'(dig_sel), 32'd0);
      chk("arst_fs", 32'(frame_start), 32'd0);
      chk("arst_pending", 32'(pending), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for an N-digit common-segment 7-segment display. It holds a hex value per digit, decodes each nibble to segments for the full 0–F range, and scans the digits one at a time at a programmable refresh rate. It also provides per-digit decimal points, per-digit blanking and leading-zero suppression. New values arrive through a load strobe and take effect only at a frame boundary, so a digit never shows a partial update.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal 1..8.
- REFRESH_DIV, 50000, clk cycles each digit stays lit; legal ≥ 2.
- SEG_ACTIVE_LOW, 0, 1 inverts `seg` and `dp_out` (0 = high lights a segment).
- DIG_ACTIVE_LOW, 0, 1 inverts `dig_sel` (0 = high selects a digit).

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = scanning; 0 = freeze scan and blank outputs.
- load  in  1  one-cycle strobe that captures `value_in`, `dp_in` and `blank_in`.
- value_in  in  4*NUM_DIGITS  nibble k goes to digit k; digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal-point request per digit.
- blank_in  in  NUM_DIGITS  forces digit k dark, including its dp.
- lz_blank  in  1  1 = suppress leading zeros (sampled live).
- seg  out  7  seg[6]=a … seg[0]=g, registered.
- dp_out  out  1  decimal point of the current digit, registered.
- dig_sel  out  NUM_DIGITS  one-hot digit strobe, registered.
- frame_start  out  1  one-cycle pulse on each tick that drives digit 0.
- pending  out  1  a captured load is waiting for the next frame boundary.

## Operation
- **Prescaler:** `pcnt` counts 0..REFRESH_DIV-1 while `enable` is 1.
  - `tick` = `enable` & (`pcnt` == REFRESH_DIV-1).
  - `pcnt` wraps to 0 on `tick`.
- **Scan index:** `idx` runs 0..NUM_DIGITS-1.
  - On `tick`, the outputs are registered from the current `idx`, then `idx` increments, wrapping from NUM_DIGITS-1 to 0.
- **Shadow/active registers:**
  - `load` copies the three inputs into the shadow register and sets `pending`.
  - On a `tick` with `idx` == 0 and `pending` set, shadow is copied to active and `pending` clears.
  - Digit 0 of that frame already decodes the new value; the shadow is bypassed into the decode.
- **Decode (on-segments):**
  - 0 abcdef; 1 bc; 2 abdeg; 3 abcdg; 4 bcfg; 5 acdfg; 6 acdefg; 7 abc
  - 8 abcdefg; 9 abcdfg; A abcefg; b cdefg; C adef; d bcdeg; E adefg; F aefg
- **Leading-zero suppression:** with `lz_blank` = 1, digit k is dark when every active nibble from k through NUM_DIGITS-1 is 0. Digit 0 is never suppressed. A suppressed digit still shows its dp.
- **Blanking:** a digit marked in `blank_in` drives `seg` off and `dp_out` off. Its `dig_sel` strobe still asserts.
- **Polarity:** inversion parameters are applied last, at the output registers.

## Timing
- **Reset values:**
  - `seg` and `dp_out` = off, polarity-adjusted.
  - `dig_sel` = none selected, polarity-adjusted.
  - `frame_start` = 0, `pending` = 0.
  - `pcnt` = 0, `idx` = 0; shadow and active registers = 0.
- **After reset:** the first `tick` occurs REFRESH_DIV cycles after the enabled deassertion of `rst`. The outputs for digit 0 and `frame_start` appear in the cycle after that `tick` edge.
- **Scan rate:** each digit is held exactly REFRESH_DIV cycles; one frame is NUM_DIGITS*REFRESH_DIV cycles.
- **Load latency:** a `load` becomes visible at the first frame boundary strictly after its capture. That is at most one frame plus one cycle.
- **Back-to-back loads:** repeated `load`s before a boundary overwrite the shadow; the last one wins.
- **`load` on the boundary `tick` cycle:** the previous shadow content is committed. The new value is captured, `pending` stays 1, and it commits at the next boundary.
- **`enable` low:** `pcnt` and `idx` hold; the next cycle drives all outputs off and `frame_start` = 0. Loads are still captured. On re-enable, counting resumes from the held `pcnt`.
- **Reset mid-scan:** the asynchronous reset clears everything immediately, including any pending load.
- **NUM_DIGITS = 1:** every `tick` is a frame boundary, and `dig_sel` stays asserted once scanning starts.

## Test plan
- **Reset and first frame.** NUM_DIGITS=4, REFRESH_DIV=4. Release reset, load 0x1234, no dp, no blank.
  - Digit 0 shows 4 = bcfg with `dig_sel` 0001.
  - `dig_sel` then steps 0010, 0100, 1000, each held exactly 4 cycles, with `frame_start` pulsing on every return to 0001.
- **Hex decode sweep.** Load each value 0x0..0xF into digit 0. Check `seg` against the decode list at the next frame, e.g. 0xE gives a,d,e,f,g lit = 1001111.
- **Frame-boundary commit.** Load 0xAAAA mid-frame.
  - Digits 1–3 keep the old value and `pending` = 1 until the boundary.
  - The next digit 0 shows A and `pending` falls.
- **Load on the boundary `tick`.** Assert `load` on the boundary `tick`: the old shadow commits, the new value commits one frame later.
- **Leading-zero suppression and blanking.** Load 0x0050 with `lz_blank`=1 and `dp_in`=0100.
  - Digit 3 is dark.
  - Digit 2 is dark except dp=1.
  - Digit 1 shows 5 and digit 0 shows 0.
  - With `blank_in`=0001, digit 0 is fully dark.
- **Enable and reset mid-scan.** Drop `enable` for 10 cycles at idx=2: outputs go off and scanning resumes at digit 2 with the remaining count. Then assert `rst` mid-digit: all outputs go off immediately and `pending` = 0.
